// File: rtl/multicycle_seq.sv
// multicycle_seq: multi-cycle sequencer for the 16-bit CPU.
//   Steps each instruction through FETCH/DECODE/EXEC/MEM/WB and decides in
//   which cycle each datapath write happens. It also runs the request/ready
//   handshake to the shared memory, with a bounded wait that ends in ERR.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   opcode[3:0]           IR opcode (valid from DECODE onward)
//   stall                 hazard stall, only honoured in FETCH
//   alu_zero              ALU zero flag, sampled in EXEC
//   mem_ready             memory completes the current request this cycle
//   imem_req, dmem_req, dmem_we      memory requests
//   ir_write, pc_write, pc_src[1:0], reg_write   datapath strobes
//   instr_done            one-cycle retire pulse
//   retired[15:0]         retired-instruction count (wraps)
//   state[2:0], halted, err          status
// Opcode map shared with the decoder:
//   0..7 ALU R/I ops, 8 LW, 9 SW, 10 BEQ, 11 BNE, 12 JUMP, 15 HALT,
//   13/14 undefined (executed as NOP).
module multicycle_seq #(
  parameter int MAX_WAIT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  opcode,
  input  logic        stall,
  input  logic        alu_zero,
  input  logic        mem_ready,
  output logic        imem_req,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        ir_write,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic        reg_write,
  output logic        instr_done,
  output logic [15:0] retired,
  output logic [2:0]  state,
  output logic        halted,
  output logic        err
);

  localparam logic [3:0] OP_LW   = 4'd8;
  localparam logic [3:0] OP_SW   = 4'd9;
  localparam logic [3:0] OP_BEQ  = 4'd10;
  localparam logic [3:0] OP_BNE  = 4'd11;
  localparam logic [3:0] OP_JUMP = 4'd12;
  localparam logic [3:0] OP_HALT = 4'd15;

  localparam logic [1:0] PC_INC = 2'd0;
  localparam logic [1:0] PC_BR  = 2'd1;
  localparam logic [1:0] PC_JMP = 2'd2;

  localparam logic [7:0] WAIT_LIM = 8'(MAX_WAIT);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5,
    S_ERR    = 3'd6
  } state_t;

  state_t     st, nxt;
  logic [7:0] wait_cnt, wait_nxt;

  // Next state, next wait count and strobes. wait_nxt defaults to 0 so the
  // counter clears on every state change and on mem_ready; only a held,
  // not-ready request advances it.
  always_comb begin
    nxt        = st;
    wait_nxt   = '0;
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = PC_INC;
    reg_write  = 1'b0;
    instr_done = 1'b0;
    unique case (st)
      S_FETCH: begin
        if (!stall) begin
          imem_req = 1'b1;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            nxt      = S_DECODE;
          end else if (wait_cnt == WAIT_LIM) begin
            nxt = S_ERR;
          end else begin
            wait_nxt = wait_cnt + 8'd1;
          end
        end
      end
      S_DECODE: begin
        if (opcode == OP_HALT) begin
          nxt = S_HALT;
        end else if (opcode == OP_JUMP) begin
          pc_write   = 1'b1;
          pc_src     = PC_JMP;
          instr_done = 1'b1;
          nxt        = S_FETCH;
        end else begin
          nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        case (opcode)
          OP_LW, OP_SW: nxt = S_MEM;
          OP_BEQ: begin
            pc_write   = alu_zero;
            pc_src     = PC_BR;
            instr_done = 1'b1;
            nxt        = S_FETCH;
          end
          OP_BNE: begin
            pc_write   = !alu_zero;
            pc_src     = PC_BR;
            instr_done = 1'b1;
            nxt        = S_FETCH;
          end
          default: begin
            if (opcode[3] == 1'b0) begin
              nxt = S_WB;                 // ALU ops 0..7
            end else begin
              instr_done = 1'b1;          // undefined opcode retires as NOP
              nxt        = S_FETCH;
            end
          end
        endcase
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (opcode == OP_SW);
        if (mem_ready) begin
          if (opcode == OP_SW) begin
            instr_done = 1'b1;
            nxt        = S_FETCH;
          end else begin
            nxt = S_WB;
          end
        end else if (wait_cnt == WAIT_LIM) begin
          nxt = S_ERR;
        end else begin
          wait_nxt = wait_cnt + 8'd1;
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        nxt        = S_FETCH;
      end
      default: nxt = st;                  // HALT / ERR are sticky until rst
    endcase

    // No strobe may fire in a reset cycle, whatever the current state.
    if (rst) begin
      imem_req   = 1'b0;
      dmem_req   = 1'b0;
      dmem_we    = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = PC_INC;
      reg_write  = 1'b0;
      instr_done = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st       <= S_FETCH;
      wait_cnt <= '0;
      retired  <= '0;
    end else begin
      st       <= nxt;
      wait_cnt <= wait_nxt;
      if (instr_done) retired <= retired + 16'd1;
    end
  end

  assign state  = st;
  assign halted = (st == S_HALT);
  assign err    = (st == S_ERR);

endmodule

// File: tb/tb_multicycle_seq.sv
module tb_multicycle_seq;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_LW   = 4'd8;
  localparam logic [3:0] OP_SW   = 4'd9;
  localparam logic [3:0] OP_BEQ  = 4'd10;
  localparam logic [3:0] OP_BNE  = 4'd11;
  localparam logic [3:0] OP_JUMP = 4'd12;
  localparam logic [3:0] OP_UND  = 4'd13;
  localparam logic [3:0] OP_HALT = 4'd15;

  // strobe bundle: {imem,dmem,we,irw,pcw,pc_src[1:0],regw,done}
  localparam logic [8:0] S_NONE  = 9'b0_0_0_0_0_00_0_0;
  localparam logic [8:0] S_FOK   = 9'b1_0_0_1_1_00_0_0;
  localparam logic [8:0] S_FWAIT = 9'b1_0_0_0_0_00_0_0;
  localparam logic [8:0] S_WB    = 9'b0_0_0_0_0_00_1_1;
  localparam logic [8:0] S_LDMEM = 9'b0_1_0_0_0_00_0_0;
  localparam logic [8:0] S_STMEM = 9'b0_1_1_0_0_00_0_1;
  localparam logic [8:0] S_BRTK  = 9'b0_0_0_0_1_01_0_1;
  localparam logic [8:0] S_BRNT  = 9'b0_0_0_0_0_01_0_1;
  localparam logic [8:0] S_JMP   = 9'b0_0_0_0_1_10_0_1;
  localparam logic [8:0] S_NOP   = 9'b0_0_0_0_0_00_0_1;

  logic clk = 1'b0, rst = 1'b1;
  logic [3:0] opcode = '0;
  logic stall = 1'b0, alu_zero = 1'b0, mem_ready = 1'b0;
  logic imem_req, dmem_req, dmem_we, ir_write, pc_write, reg_write, instr_done;
  logic [1:0]  pc_src;
  logic [15:0] retired;
  logic [2:0]  state;
  logic halted, err;

  multicycle_seq #(.MAX_WAIT(8)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .stall(stall), .alu_zero(alu_zero),
    .mem_ready(mem_ready), .imem_req(imem_req), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .ir_write(ir_write), .pc_write(pc_write),
    .pc_src(pc_src), .reg_write(reg_write), .instr_done(instr_done),
    .retired(retired), .state(state), .halted(halted), .err(err)
  );

  always #5 clk = ~clk;

  wire [8:0] strobes = {imem_req, dmem_req, dmem_we, ir_write, pc_write,
                        pc_src, reg_write, instr_done};

  typedef struct {
    logic [3:0] op;
    logic       stl;
    logic       az;
    logic       rdy;
    logic [2:0] st;
    logic [8:0] s;
  } vec_t;

  vec_t vecs[$];
  int   n_pass = 0, n_tot = 0;
  logic [15:0] exp_ret;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic add(input logic [3:0] op, input logic stl, input logic az,
                     input logic rdy, input logic [2:0] st, input logic [8:0] s);
    vec_t v;
    v.op = op; v.stl = stl; v.az = az; v.rdy = rdy; v.st = st; v.s = s;
    vecs.push_back(v);
  endtask

  // drive one cycle's inputs away from the active edge, settle, then sample
  task automatic step(input logic r, input logic [3:0] op, input logic stl,
                      input logic az, input logic rdy);
    @(negedge clk);
    rst = r; opcode = op; stall = stl; alu_zero = az; mem_ready = rdy;
    #1;
  endtask

  initial begin
    // ADD, zero-wait: FETCH, DECODE, EXEC, WB
    add(OP_ADD, 0, 0, 1, 3'd0, S_FOK);
    add(OP_ADD, 0, 0, 1, 3'd1, S_NONE);
    add(OP_ADD, 0, 0, 1, 3'd2, S_NONE);
    add(OP_ADD, 0, 0, 1, 3'd4, S_WB);
    // LW with data ready delayed 3 cycles: 8 cycles total
    add(OP_LW, 0, 0, 1, 3'd0, S_FOK);
    add(OP_LW, 0, 0, 1, 3'd1, S_NONE);
    add(OP_LW, 0, 0, 1, 3'd2, S_NONE);
    add(OP_LW, 0, 0, 0, 3'd3, S_LDMEM);
    add(OP_LW, 0, 0, 0, 3'd3, S_LDMEM);
    add(OP_LW, 0, 0, 0, 3'd3, S_LDMEM);
    add(OP_LW, 0, 0, 1, 3'd3, S_LDMEM);
    add(OP_LW, 0, 0, 1, 3'd4, S_WB);
    // BEQ taken
    add(OP_BEQ, 0, 1, 1, 3'd0, S_FOK);
    add(OP_BEQ, 0, 1, 1, 3'd1, S_NONE);
    add(OP_BEQ, 0, 1, 1, 3'd2, S_BRTK);
    // BNE with zero set: not taken, still retires
    add(OP_BNE, 0, 1, 1, 3'd0, S_FOK);
    add(OP_BNE, 0, 1, 1, 3'd1, S_NONE);
    add(OP_BNE, 0, 1, 1, 3'd2, S_BRNT);
    // BNE with zero clear: taken
    add(OP_BNE, 0, 0, 1, 3'd0, S_FOK);
    add(OP_BNE, 0, 0, 1, 3'd1, S_NONE);
    add(OP_BNE, 0, 0, 1, 3'd2, S_BRTK);
    // stall 5 cycles in FETCH, then JUMP
    for (int i = 0; i < 5; i++) add(OP_JUMP, 1, 0, 1, 3'd0, S_NONE);
    add(OP_JUMP, 0, 0, 1, 3'd0, S_FOK);
    add(OP_JUMP, 0, 0, 1, 3'd1, S_JMP);
    // fetch waiting, stall drops the request, restart after stall falls
    add(OP_UND, 0, 0, 0, 3'd0, S_FWAIT);
    add(OP_UND, 0, 0, 0, 3'd0, S_FWAIT);
    add(OP_UND, 1, 0, 0, 3'd0, S_NONE);
    add(OP_UND, 0, 0, 1, 3'd0, S_FOK);
    // undefined opcode retires as NOP
    add(OP_UND, 0, 0, 1, 3'd1, S_NONE);
    add(OP_UND, 0, 0, 1, 3'd2, S_NOP);
    // SW zero-wait: 4 cycles
    add(OP_SW, 0, 0, 1, 3'd0, S_FOK);
    add(OP_SW, 0, 0, 1, 3'd1, S_NONE);
    add(OP_SW, 0, 0, 1, 3'd2, S_NONE);
    add(OP_SW, 0, 0, 1, 3'd3, S_STMEM);
    // stall is ignored once past FETCH
    add(OP_ADD, 0, 0, 1, 3'd0, S_FOK);
    add(OP_ADD, 1, 0, 1, 3'd1, S_NONE);
    add(OP_ADD, 1, 0, 1, 3'd2, S_NONE);
    add(OP_ADD, 1, 0, 1, 3'd4, S_WB);
    add(OP_ADD, 1, 0, 1, 3'd0, S_NONE);

    // reset state
    step(1, OP_ADD, 0, 0, 1);
    step(1, OP_ADD, 0, 0, 1);
    chk("rst_state", state, 3'd0);
    chk("rst_strobes", strobes, S_NONE);
    chk("rst_retired", retired, 16'd0);
    chk("rst_flags", {halted, err}, 2'b00);

    exp_ret = 16'd0;
    foreach (vecs[i]) begin
      step(0, vecs[i].op, vecs[i].stl, vecs[i].az, vecs[i].rdy);
      chk($sformatf("v%0d_state", i), state, vecs[i].st);
      chk($sformatf("v%0d_strobes", i), strobes, vecs[i].s);
      chk($sformatf("v%0d_retired", i), retired, exp_ret);
      exp_ret = exp_ret + 16'(vecs[i].s[0]);
    end

    // exactly MAX_WAIT wait cycles are tolerated
    for (int i = 0; i < 8; i++) begin
      step(0, OP_JUMP, 0, 0, 0);
      chk("wait_ok_req", {state, imem_req}, {3'd0, 1'b1});
    end
    step(0, OP_JUMP, 0, 0, 1);
    chk("wait_ok_last", strobes, S_FOK);
    step(0, OP_JUMP, 0, 0, 1);
    chk("wait_ok_decode", {state, strobes}, {3'd1, S_JMP});

    // one more wait cycle than allowed ends in ERR
    for (int i = 0; i < 9; i++) begin
      step(0, OP_ADD, 0, 0, 0);
      chk("err_req", {state, imem_req, err}, {3'd0, 1'b1, 1'b0});
    end
    for (int i = 0; i < 3; i++) begin
      step(0, OP_ADD, 0, 0, 1);
      chk("err_sticky", {state, err, strobes}, {3'd6, 1'b1, S_NONE});
    end
    step(1, OP_ADD, 0, 0, 1);
    chk("err_rst_strobes", strobes, S_NONE);
    step(0, OP_ADD, 1, 0, 0);
    chk("err_rst_state", {state, err}, {3'd0, 1'b0});
    chk("err_rst_retired", retired, 16'd0);

    // reset in the middle of a data request
    step(0, OP_LW, 0, 0, 1);
    step(0, OP_LW, 0, 0, 1);
    step(0, OP_LW, 0, 0, 1);
    step(0, OP_LW, 0, 0, 0);
    chk("midreq_mem", {state, strobes}, {3'd3, S_LDMEM});
    step(1, OP_LW, 0, 0, 0);
    chk("midreq_rst_strobes", strobes, S_NONE);
    step(0, OP_LW, 1, 0, 0);
    chk("midreq_fetch", state, 3'd0);

    // HALT: no retire, sticky
    step(0, OP_HALT, 0, 0, 1);
    step(0, OP_HALT, 0, 0, 1);
    chk("halt_decode", {state, strobes}, {3'd1, S_NONE});
    for (int i = 0; i < 3; i++) begin
      step(0, OP_HALT, 0, 0, 1);
      chk("halt_hold", {state, halted, strobes}, {3'd5, 1'b1, S_NONE});
    end
    chk("halt_retired", retired, 16'd0);

    // retired wraps: the count is preset to 16'hFFFF directly to keep the run short
    step(1, OP_JUMP, 1, 0, 0);
    step(0, OP_JUMP, 1, 0, 0);
    force dut.retired = 16'hFFFF;
    #1;
    release dut.retired;
    step(0, OP_JUMP, 1, 0, 0);
    chk("wrap_preset", retired, 16'hFFFF);
    step(0, OP_JUMP, 0, 0, 1);
    step(0, OP_JUMP, 0, 0, 1);
    chk("wrap_done", strobes, S_JMP);
    step(0, OP_JUMP, 1, 0, 0);
    chk("wrap_zero", retired, 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
